pr_timer: RTL and testbench

Programmable down-counting timer that sits on the processor's device bus (PrAddr/PrWD/PrWe/PrRD) as a bus responder and drives one hardware interrupt line into HWInt[7:2]. Software configures it through three word registers: CTRL, PRESET, and COUNT. It counts down once per clock and raises IRQ when COUNT reaches zero, either one-shot or auto-reload. Address decode and chip-select are done by the system bridge; this block sees only its own word offset and a qualified write enable.

---
 rtl/pr_timer_pkg.sv | 33 +++
 rtl/pr_timer_if.sv | 11 +
 rtl/pr_timer.sv | 146 ++++++++++++++
 tb/tb_pr_timer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pr_timer_pkg.sv
// Shared definitions for the pr_timer device-bus timer: register offsets,
// CTRL bit positions, mode and FSM state encodings.
package pr_timer_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'd0,
        MODE_RELOAD  = 2'd1,
        MODE_RSVD2   = 2'd2,
        MODE_RSVD3   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    // Only the reload encoding auto-restarts; the reserved encodings act as one-shot.
    function automatic logic is_reload(input logic [1:0] mode);
        return (mode == MODE_RELOAD);
    endfunction

endpackage

// File: rtl/pr_timer_if.sv
// Device-bus responder port of pr_timer: word offset, qualified write strobe,
// write data and combinational read data.
interface pr_timer_if;
    logic [1:0]  Addr;
    logic        We;
    logic [31:0] WD;
    logic [31:0] RD;

    modport master (output Addr, output We, output WD, input RD);
    modport slave  (input Addr, input We, input WD, output RD);
endinterface

// File: rtl/pr_timer.sv
// Programmable down-counting timer with CTRL/PRESET/COUNT registers and a
// maskable interrupt, one-shot or auto-reload.
module pr_timer
    import pr_timer_pkg::*;
(
    input  logic      Clk,
    input  logic      Reset,
    pr_timer_if.slave bus,
    output logic      IRQ
);

    state_e      state_r;
    state_e      state_s;
    logic        en_r;
    logic        en_s;
    logic [1:0]  mode_r;
    logic [1:0]  mode_s;
    logic        im_r;
    logic        im_s;
    logic [31:0] preset_r;
    logic [31:0] preset_s;
    logic [31:0] count_r;
    logic [31:0] count_s;
    logic        pend_r;
    logic        pend_s;
    logic        pend_auto_r;
    logic        pend_auto_s;
    logic        irq_r;
    logic        ctrl_wr_s;
    logic        preset_wr_s;
    logic        pend_set_s;
    logic        en_clr_s;

    assign ctrl_wr_s   = bus.We && (bus.Addr == ADDR_CTRL);
    assign preset_wr_s = bus.We && (bus.Addr == ADDR_PRESET);

    // Countdown sequencing: next state, next COUNT and interrupt events.
    always_comb begin
        state_s     = state_r;
        count_s     = count_r;
        pend_set_s  = 1'b0;
        pend_auto_s = 1'b0;
        en_clr_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (en_r) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                count_s = preset_r;
                state_s = ST_CNT;
            end
            ST_CNT: begin
                if (!en_r) begin
                    state_s = ST_IDLE;
                end else if (count_r == 32'd0) begin
                    state_s = ST_INT;
                end else begin
                    count_s = count_r - 32'd1;
                end
            end
            ST_INT: begin
                pend_set_s = 1'b1;
                if (is_reload(mode_r)) begin
                    // Mode is sampled here, so a mid-count change lands at this point.
                    count_s     = preset_r;
                    state_s     = ST_CNT;
                    pend_auto_s = 1'b1;
                end else begin
                    en_clr_s = 1'b1;
                    state_s  = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Merge CPU writes with FSM side effects; a CTRL write beats the one-shot
    // Enable clear, while an interrupt event beats the write-clear of pend.
    always_comb begin
        if (ctrl_wr_s) begin
            en_s   = bus.WD[CTRL_EN];
            mode_s = bus.WD[CTRL_MODE_HI:CTRL_MODE_LO];
            im_s   = bus.WD[CTRL_IM];
        end else begin
            en_s   = en_r & ~en_clr_s;
            mode_s = mode_r;
            im_s   = im_r;
        end
        if (preset_wr_s) begin
            preset_s = bus.WD;
        end else begin
            preset_s = preset_r;
        end
        if (pend_set_s) begin
            pend_s = 1'b1;
        end else if (ctrl_wr_s || pend_auto_r) begin
            pend_s = 1'b0;
        end else begin
            pend_s = pend_r;
        end
    end

    // Zero-latency register read mux; unmapped offset reads zero.
    always_comb begin
        case (bus.Addr)
            ADDR_CTRL:   bus.RD = {28'd0, im_r, mode_r, en_r};
            ADDR_PRESET: bus.RD = preset_r;
            ADDR_COUNT:  bus.RD = count_r;
            default:     bus.RD = 32'd0;
        endcase
    end

    // State and register update with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r     <= ST_IDLE;
            en_r        <= 1'b0;
            mode_r      <= 2'd0;
            im_r        <= 1'b0;
            preset_r    <= 32'd0;
            count_r     <= 32'd0;
            pend_r      <= 1'b0;
            pend_auto_r <= 1'b0;
            irq_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            en_r        <= en_s;
            mode_r      <= mode_s;
            im_r        <= im_s;
            preset_r    <= preset_s;
            count_r     <= count_s;
            pend_r      <= pend_s;
            pend_auto_r <= pend_auto_s;
            irq_r       <= im_s & pend_s;
        end
    end

    assign IRQ = irq_r;

endmodule

// File: tb/tb_pr_timer.sv
// Self-checking bench for pr_timer: a timeline model (edges since LOAD) checked
// every cycle, plus directed literal expectations from the written timing rules.
module tb_pr_timer;

    logic Clk = 1'b0;
    logic Reset;
    logic IRQ;
    pr_timer_if bus ();

    pr_timer dut (.Clk(Clk), .Reset(Reset), .bus(bus), .IRQ(IRQ));

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: registers plus a timeline measured from the most recent load.
    bit          m_en, m_im, m_pend, m_pulse, m_busy;
    logic [1:0]  m_mode;
    logic [31:0] m_preset, m_count;
    longint      m_n;
    int          edge_n = 0;
    int          m_load_at;
    int          k;
    bit          pend_set, en_clear, wr_ctrl;

    always @(posedge Clk) begin
        if (Reset) begin
            m_en = 0; m_im = 0; m_pend = 0; m_pulse = 0; m_busy = 0;
            m_mode = 2'd0; m_preset = 32'd0; m_count = 32'd0; m_n = 0;
        end else begin
            pend_set = 0;
            en_clear = 0;
            wr_ctrl  = bus.We && (bus.Addr == 2'd0);
            if (!m_busy) begin
                if (m_en) begin
                    m_busy    = 1;
                    m_load_at = edge_n + 1;
                end
            end else if (edge_n == m_load_at) begin
                m_n     = longint'(m_preset);
                m_count = m_preset;
            end else begin
                k = edge_n - m_load_at;
                if (k <= m_n + 1) begin
                    if (!m_en) m_busy = 0;
                    else if (k <= m_n) m_count = 32'(m_n - k);
                end else begin
                    pend_set = 1;
                    if (m_mode == 2'd1) begin
                        m_load_at = edge_n;
                        m_n       = longint'(m_preset);
                        m_count   = m_preset;
                    end else begin
                        en_clear = 1;
                        m_busy   = 0;
                    end
                end
            end
            if (pend_set) m_pend = 1;
            else if (wr_ctrl || m_pulse) m_pend = 0;
            m_pulse = pend_set && (m_mode == 2'd1);
            if (wr_ctrl) begin
                m_en   = bus.WD[0];
                m_mode = bus.WD[2:1];
                m_im   = bus.WD[3];
            end else if (en_clear) begin
                m_en = 0;
            end
            if (bus.We && bus.Addr == 2'd1) m_preset = bus.WD;
        end
        edge_n++;
    end

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    always @(negedge Clk) begin
        if (cmp_on) begin
            check("model_rd", bus.RD, model_rd(bus.Addr));
            check("model_irq", {31'd0, IRQ}, {31'd0, m_im & m_pend});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #2;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.Addr = a;
        bus.WD   = d;
        bus.We   = 1'b1;
        step(1);
        bus.We   = 1'b0;
        bus.Addr = 2'd2;
    endtask

    task automatic peek(input logic [1:0] a, input logic [31:0] exp, input string name);
        bus.Addr = a;
        #1;
        check(name, bus.RD, exp);
        bus.Addr = 2'd2;
    endtask

    initial begin
        Reset    = 1'b1;
        bus.Addr = 2'd2;
        bus.We   = 1'b0;
        bus.WD   = 32'd0;
        step(1);
        Reset  = 1'b0;
        cmp_on = 1'b1;
        peek(2'd0, 32'd0, "rst_ctrl"); step(1);
        peek(2'd1, 32'd0, "rst_preset"); step(1);
        peek(2'd2, 32'd0, "rst_count");
        check("rst_irq", {31'd0, IRQ}, 32'd0);

        // One-shot, N=5: IRQ after edge N+4.
        wr(2'd1, 32'd5); wr(2'd0, 32'h9);
        step(2); peek(2'd2, 32'd5, "m0_load");
        step(5); peek(2'd2, 32'd0, "m0_zero");
        step(1); check("m0_irq_pre", {31'd0, IRQ}, 32'd0);
        step(1); check("m0_irq_rise", {31'd0, IRQ}, 32'd1);
        peek(2'd0, 32'h8, "m0_en_cleared");
        step(3); check("m0_irq_hold", {31'd0, IRQ}, 32'd1);
        wr(2'd0, 32'h8); check("m0_irq_clr", {31'd0, IRQ}, 32'd0);

        // Auto-reload, N=3: pulses after edges 7, 12, 17.
        wr(2'd1, 32'd3); wr(2'd0, 32'hB);
        step(6); check("m1_pre", {31'd0, IRQ}, 32'd0);
        step(1); check("m1_pulse1", {31'd0, IRQ}, 32'd1);
        peek(2'd2, 32'd3, "m1_reload");
        step(1); check("m1_drop1", {31'd0, IRQ}, 32'd0);
        step(4); check("m1_pulse2", {31'd0, IRQ}, 32'd1);
        step(1); check("m1_drop2", {31'd0, IRQ}, 32'd0);
        wr(2'd0, 32'h0);
        step(5);

        // Masked interrupt; enabling the mask via a CTRL write also clears pend.
        wr(2'd1, 32'd2); wr(2'd0, 32'h1);
        step(8); peek(2'd0, 32'h0, "im0_ctrl");
        check("im0_irq", {31'd0, IRQ}, 32'd0);
        wr(2'd0, 32'h8); check("im0_after_im", {31'd0, IRQ}, 32'd0);
        step(2); check("im0_stays", {31'd0, IRQ}, 32'd0);

        // Mid-count disable freezes COUNT; re-enable reloads; PRESET write is deferred.
        wr(2'd1, 32'd10); wr(2'd0, 32'h9);
        step(5); wr(2'd0, 32'h8);
        step(3); peek(2'd2, 32'd6, "mid_hold");
        wr(2'd0, 32'h9);
        step(2); peek(2'd2, 32'd10, "mid_reload");
        wr(2'd1, 32'd20);
        step(1); peek(2'd2, 32'd8, "mid_preset_deferred");
        step(12); check("mid_irq", {31'd0, IRQ}, 32'd1);
        wr(2'd0, 32'h8);

        // PRESET=0: IRQ after edge 4.
        wr(2'd1, 32'd0); wr(2'd0, 32'h9);
        step(3); check("p0_pre", {31'd0, IRQ}, 32'd0);
        step(1); check("p0_irq", {31'd0, IRQ}, 32'd1);
        wr(2'd0, 32'h8);

        // Read-only COUNT and unmapped offset.
        wr(2'd2, 32'h55); peek(2'd2, 32'd0, "count_ro");
        step(1); wr(2'd3, 32'hAA); peek(2'd3, 32'd0, "addr3_zero");

        // Upper CTRL bits; mode 3 behaves as one-shot; then reset while IRQ is high.
        step(1); wr(2'd0, 32'hFFFF_FFFF); peek(2'd0, 32'hF, "ctrl_upper_zero");
        step(4); check("m3_irq", {31'd0, IRQ}, 32'd1);
        step(3); check("m3_hold", {31'd0, IRQ}, 32'd1);
        wr(2'd1, 32'd7);
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
        check("rst2_irq", {31'd0, IRQ}, 32'd0);
        peek(2'd1, 32'd0, "rst2_preset"); step(1);
        peek(2'd0, 32'd0, "rst2_ctrl"); step(1);
        peek(2'd2, 32'd0, "rst2_count");
        step(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
